// File: rtl/imul_var_lat_pkg.sv
// Shared definitions for the variable-latency multiplier.
// Controller states and datapath mux encodings.
package imul_var_lat_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic A_MUX_LD    = 1'b0;
  localparam logic A_MUX_SHIFT = 1'b1;

  localparam logic B_MUX_LD    = 1'b0;
  localparam logic B_MUX_SHIFT = 1'b1;

  localparam logic RES_MUX_CLR = 1'b0;
  localparam logic RES_MUX_ACC = 1'b1;

  localparam logic ADD_MUX_BYP = 1'b0;
  localparam logic ADD_MUX_ADD = 1'b1;

endpackage

// File: rtl/imul_var_lat_ctrl.sv
// Control unit for the variable-latency shift-add multiplier.
// Skips zero runs of B using the datapath-supplied shift amount.
module imul_var_lat_ctrl
  import imul_var_lat_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_val,
  output logic       req_rdy,
  output logic       resp_val,
  input  logic       resp_rdy,
  input  logic       b_lsb,
  input  logic       b_zero,
  input  logic [3:0] shamt,
  output logic       a_mux_sel,
  output logic       b_mux_sel,
  output logic       res_mux_sel,
  output logic       add_mux_sel,
  output logic       a_en,
  output logic       b_en,
  output logic       res_en,
  output logic       busy
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cnt_done;

  // Bits of B consumed after this iteration's shift.
  assign w_cnt_nxt  = r_cnt + {{(CNT_W-4){1'b0}}, shamt};
  assign w_cnt_done = (w_cnt_nxt >= CNT_W'(WIDTH));

  // State and consumed-bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req_val) begin
            r_cnt   <= '0;
            r_state <= CALC;
          end
        end
        CALC: begin
          if (b_zero) begin
            r_state <= DONE;
          end else begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_done) r_state <= DONE;
          end
        end
        DONE: begin
          if (resp_rdy) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Handshake, select and enable decode; all quiet while in reset.
  always_comb begin
    req_rdy     = 1'b0;
    resp_val    = 1'b0;
    a_mux_sel   = A_MUX_LD;
    b_mux_sel   = B_MUX_LD;
    res_mux_sel = RES_MUX_CLR;
    add_mux_sel = ADD_MUX_BYP;
    a_en        = 1'b0;
    b_en        = 1'b0;
    res_en      = 1'b0;
    busy        = 1'b0;
    if (reset) begin
      req_rdy = 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          req_rdy = 1'b1;
          if (req_val) begin
            a_en   = 1'b1;
            b_en   = 1'b1;
            res_en = 1'b1;
          end
        end
        CALC: begin
          busy = 1'b1;
          if (!b_zero) begin
            a_en        = 1'b1;
            b_en        = 1'b1;
            res_en      = 1'b1;
            a_mux_sel   = A_MUX_SHIFT;
            b_mux_sel   = B_MUX_SHIFT;
            res_mux_sel = RES_MUX_ACC;
            add_mux_sel = b_lsb ? ADD_MUX_ADD : ADD_MUX_BYP;
          end
        end
        DONE: begin
          busy     = 1'b1;
          resp_val = 1'b1;
        end
        default: begin
          req_rdy = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imul_var_lat_ctrl.sv
// Bench for imul_var_lat_ctrl with a behavioural datapath model.
// Scoreboard holds expected product and first-response latency.
module tb_imul_var_lat_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_val;
  logic        req_rdy;
  logic        resp_val;
  logic        resp_rdy;
  logic        b_lsb;
  logic        b_zero;
  logic [3:0]  shamt;
  logic        a_mux_sel;
  logic        b_mux_sel;
  logic        res_mux_sel;
  logic        add_mux_sel;
  logic        a_en;
  logic        b_en;
  logic        res_en;
  logic        busy;

  imul_var_lat_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy),
    .resp_val(resp_val), .resp_rdy(resp_rdy),
    .b_lsb(b_lsb), .b_zero(b_zero), .shamt(shamt),
    .a_mux_sel(a_mux_sel), .b_mux_sel(b_mux_sel),
    .res_mux_sel(res_mux_sel), .add_mux_sel(add_mux_sel),
    .a_en(a_en), .b_en(b_en), .res_en(res_en),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [31:0] m_a, m_b, m_res;

  function automatic logic [3:0] calc_shamt(input logic [31:0] b);
    logic [3:0] s;
    if (b[0]) return 4'd1;
    s = 4'd8;
    for (int i = 7; i >= 1; i--)
      if (b[i]) s = 4'(i);
    return s;
  endfunction

  always_comb begin
    shamt  = calc_shamt(m_b);
    b_lsb  = m_b[0];
    b_zero = (m_b == 32'd0);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_a   <= '0;
      m_b   <= '0;
      m_res <= '0;
    end else begin
      if (a_en) m_a <= a_mux_sel ? (m_a << shamt) : op_a;
      if (b_en) m_b <= b_mux_sel ? (m_b >> shamt) : op_b;
      if (res_en)
        m_res <= !res_mux_sel ? 32'd0 :
                 add_mux_sel ? (m_res + m_a) : m_res;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Scoreboard and monitor
  typedef struct {
    logic [31:0] res;
    int          lat;
    int          c0;
  } exp_t;
  exp_t sb[$];
  bit   seen = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      seen = 1'b0;
    end else if (resp_val) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_resp: resp_val=1 with empty scoreboard (cycle %0d)",
                 cyc);
      end else begin
        if (!seen) begin
          chk("latency", 32'(cyc - sb[0].c0), 32'(sb[0].lat));
          seen = 1'b1;
        end
        if (resp_rdy) begin
          chk("result", m_res, sb[0].res);
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // Iteration trace: {add_mux_sel, shamt} per accumulating CALC cycle
  logic [4:0] trace[$];
  always @(negedge clk)
    if (!reset && res_en && res_mux_sel)
      trace.push_back({add_mux_sel, shamt});

  always @(negedge clk)
    if (!reset && busy && !resp_val && !b_zero)
      assert (shamt != 4'd0)
      else $error("shamt of zero presented in CALC");

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat,
                       input bit push);
    int t;
    t = 0;
    @(negedge clk);
    while (!req_rdy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_rdy) begin
      chk("req_rdy_timeout", 32'(req_rdy), 32'd1);
    end
    op_a    = a;
    op_b    = b;
    req_val = 1'b1;
    if (push) sb.push_back('{res: exp, lat: lat, c0: cyc});
    @(posedge clk);
    #1 req_val = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || sb.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy || sb.size() != 0)
      chk("idle_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_trace(input string nm, input logic [4:0] e[$]);
    chk({nm, "_len"}, 32'(trace.size()), 32'(e.size()));
    if (trace.size() == e.size())
      for (int i = 0; i < e.size(); i++)
        chk(nm, 32'(trace[i]), 32'(e[i]));
  endtask

  logic [4:0] exp_tr[$];
  int         nresp;

  initial begin
    reset    = 1'b1;
    req_val  = 1'b1;
    resp_rdy = 1'b0;

    // Reset held 3 cycles, req_val asserted to prove gating
    repeat (3) begin
      @(negedge clk);
      chk("reset_outs",
          {req_rdy, resp_val, a_en, b_en, res_en, a_mux_sel,
           b_mux_sel, res_mux_sel, add_mux_sel, busy},
          10'b1000000000);
    end
    req_val = 1'b0;
    reset   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_outs",
          {req_rdy, resp_val, a_en, b_en, res_en, a_mux_sel,
           b_mux_sel, res_mux_sel, add_mux_sel, busy},
          10'b1000000000);
    end
    @(posedge clk);
    #1 resp_rdy = 1'b1;

    // B = 0: one CALC cycle with no enables
    issue(32'h1234_5678, 32'h0, 32'h0, 2, 1'b1);
    @(negedge clk);
    chk("bzero_calc", {busy, resp_val, a_en, b_en, res_en}, 5'b10000);
    wait_idle();

    // B = 5
    trace.delete();
    issue(32'h13, 32'h5, 32'h5F, 5, 1'b1);
    wait_idle();
    exp_tr = '{5'h11, 5'h01, 5'h11};
    chk_trace("b5_trace", exp_tr);

    // B = 0x80000000: exit on count with final add
    trace.delete();
    issue(32'h3, 32'h8000_0000, 32'h8000_0000, 6, 1'b1);
    wait_idle();
    exp_tr = '{5'h08, 5'h08, 5'h08, 5'h07, 5'h11};
    chk_trace("b80_trace", exp_tr);

    // Backpressure in DONE with a held request
    @(posedge clk);
    #1 resp_rdy = 1'b0;
    issue(32'h101, 32'h3, 32'h303, 4, 1'b1);
    for (int t = 0; t < 50 && !resp_val; t++) @(negedge clk);
    chk("bp_resp_seen", 32'(resp_val), 32'd1);
    op_a    = 32'hDEAD;
    op_b    = 32'h1;
    req_val = 1'b1;
    repeat (4) begin
      chk("bp_hold", {resp_val, req_rdy, a_en, b_en, res_en, busy},
          6'b100001);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    req_val  = 1'b0;
    resp_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("after_hs", {req_rdy, busy, resp_val}, 3'b100);

    // Reset mid-CALC drops the transaction
    issue(32'h7, 32'hFFFF_FFFF, 32'h0, 0, 1'b0);
    repeat (9) @(negedge clk);
    chk("pre_reset_busy", {busy, resp_val}, 2'b10);
    reset = 1'b1;
    #1;
    chk("mid_reset",
        {busy, req_rdy, resp_val, a_en, b_en, res_en}, 6'b010000);
    @(posedge clk);
    #1 reset = 1'b0;
    nresp = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_val) nresp++;
    end
    chk("no_resp_after_reset", 32'(nresp), 32'd0);

    // Full-length run after reset: 32 CALC cycles
    issue(32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 33, 1'b1);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imul_var_lat_ctrl.md
Name: imul_var_lat_ctrl

Overview:
Control unit for the variable-latency iterative integer multiplier. It runs the val/rdy request and response handshakes and sequences the shift-add datapath. In each iteration it uses the shift amount produced by the datapath's shift-amount calculator to skip runs of zero bits in operand B. It holds no operand data; it drives mux selects and enables and reads datapath status bits.

Parameters:
WIDTH, 32, operand/result width in bits; loop terminates once WIDTH bits of B have been consumed
CNT_W, $clog2(WIDTH)+1, width of consumed-bit counter

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
req_val  input  1  request valid
req_rdy  output  1  request ready
resp_val  output  1  response valid
resp_rdy  input  1  response ready
b_lsb  input  1  datapath B register bit 0
b_zero  input  1  datapath B register == 0
shamt  input  4  shift amount from datapath calc block (1..8)
a_mux_sel  output  1  A reg source: LD (0) request operand, SHIFT (1) A << shamt
b_mux_sel  output  1  B reg source: LD (0) request operand, SHIFT (1) B >> shamt
res_mux_sel  output  1  result reg source: CLR (0) zero, ACC (1) adder/bypass output
add_mux_sel  output  1  BYP (0) result unchanged, ADD (1) result + A
a_en  output  1  A register enable
b_en  output  1  B register enable
res_en  output  1  result register enable
busy  output  1  high in CALC or DONE

Behaviour:
- State register and shift counter cnt[CNT_W-1:0]; asynchronous reset -> state IDLE, cnt 0.
- All outputs are combinational from state and inputs (Moore for handshake signals).
- Values while reset is asserted: req_rdy=1, resp_val=0, all enables 0, all selects 0, busy=0.
- IDLE:
  - req_rdy=1.
  - On req_val: a_en=b_en=res_en=1, a/b_mux_sel=LD, res_mux_sel=CLR, cnt<=0, next state CALC.
  - Otherwise all enables are 0.
- CALC (req_rdy=0, resp_val=0):
  - If b_zero: no enables, next state DONE.
  - Else: a_en=b_en=res_en=1, a/b_mux_sel=SHIFT, res_mux_sel=ACC, add_mux_sel=b_lsb, cnt<=cnt+shamt (CNT_W-bit add, no overflow since cnt<WIDTH and shamt<=8).
  - Within the else branch: if cnt+shamt >= WIDTH, next state DONE; else stay in CALC.
- DONE:
  - resp_val=1, no enables.
  - On resp_rdy, next state IDLE.
  - IDLE asserts req_rdy the following cycle. There is no request/response overlap; a new request is accepted one cycle after response handshake.
- Latency from request accept edge to resp_val: 1 + k cycles.
  - k = number of CALC cycles. Minimum k=1 (B=0).
  - Maximum k=WIDTH (B=all ones, shamt 1 each).
- Shamt is used verbatim. The datapath reports 1 when bit0 is set (shift past the added bit) and 8 for an all-zero low byte. The controller does not validate shamt; shamt=0 is illegal input and is an assertion error in the bench.
- req_val in CALC/DONE is ignored (req_rdy=0); the requester must hold it.
- resp_rdy outside DONE is ignored.
- Reset mid-operation: immediately IDLE, cnt=0. The in-flight transaction is dropped and no response is produced.
- busy = (state != IDLE).

Decomposition:
- Package imul_var_lat_pkg: state enum {IDLE, CALC, DONE}; localparams A_MUX_LD/SHIFT, B_MUX_LD/SHIFT, RES_MUX_CLR/ACC, ADD_MUX_BYP/ADD. The datapath shares these.
- No sub-module in the controller. A top-level imul_var_lat wraps this controller, the datapath and the shift-amount calculator.

Test Plan:
- Reset held 3 cycles, then released, no req -> req_rdy=1, resp_val=0, all en=0, busy=0 throughout.
- Req B=0x00000000 accepted at cycle 0 -> CALC cycle 1 with b_zero=1 and no enables; resp_val=1 at cycle 2; resp_rdy=1 -> IDLE cycle 3.
- B=0x00000005, bench datapath model -> CALC iterations with (b_lsb, shamt) = (1,1), (0,1), (1,1), then b_zero. add_mux_sel sequence is 1,0,1. resp_val is asserted at cycle 5; result = 5*A.
- B=0x80000000 -> shamt sequence 8,8,8,7,1 with cnt 8,16,24,31,32. The exit on cnt>=32 occurs in the same cycle as the final add (add_mux_sel=1). resp_val at cycle 6; result = A<<31.
- Backpressure: resp_rdy=0 for 4 cycles in DONE -> resp_val held, no enables; req_val=1 meanwhile is not accepted (req_rdy=0).
- Reset asserted mid-CALC (B=0xFFFFFFFF, cycle 10) -> same-cycle IDLE, cnt=0, busy=0. No resp_val ever appears; the next request completes normally.
